// File: rtl/ammeter_pwm_array.sv
// Multi-channel panel-meter PWM driver: per-channel slew limiter feeding either a
// first-order sigma-delta modulator or a shared-counter PWM.
module ammeter_pwm_array #(
    parameter int unsigned CH       = 3,
    parameter int unsigned W        = 8,
    parameter int unsigned STEP_DIV = 1000
) (
    input  logic            clk,
    input  logic            Rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic            ramp_en,
    input  logic [CH*W-1:0] duty_i,
    input  logic [CH-1:0]   load_i,
    output logic [CH-1:0]   PWM,
    output logic [CH-1:0]   busy_o,
    output logic            wrap_o
);

    localparam int unsigned PW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [W-1:0]  CntMax  = '1;
    localparam logic [PW-1:0] PresMax = PW'(STEP_DIV - 1);

    logic [CH-1:0][W-1:0] tgt_q, tgt_d;
    logic [CH-1:0][W-1:0] cur_q, cur_d;
    logic [CH-1:0][W-1:0] act_q, act_d;
    logic [CH-1:0][W:0]   acc_q, acc_d;
    logic [CH-1:0]        pwm_q, pwm_d;
    logic [CH-1:0]        busy_q, busy_d;
    logic [W-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]        pres_q, pres_d;
    logic                 wrap_q, wrap_d;
    logic                 mode_q;
    logic                 mode_chg, tick, wrap;

    always_comb begin
        mode_chg = (mode != mode_q);
        tick     = en && (pres_q == PresMax);
        wrap     = en && !mode_chg && (cnt_q == CntMax);
        pres_d   = (!en || tick) ? '0 : pres_q + PW'(1);
        cnt_d    = (!en || mode_chg) ? '0 : cnt_q + W'(1);
        wrap_d   = wrap;

        for (int unsigned k = 0; k < CH; k++) begin
            tgt_d[k]  = load_i[k] ? duty_i[k*W +: W] : tgt_q[k];
            busy_d[k] = (cur_q[k] != tgt_q[k]);

            cur_d[k] = cur_q[k];
            if (en) begin
                if (!ramp_en) begin
                    cur_d[k] = tgt_q[k];
                end else if (tick) begin
                    // A load landing on a tick edge steers this step toward the new target.
                    if (cur_q[k] < tgt_d[k]) begin
                        cur_d[k] = cur_q[k] + W'(1);
                    end else if (cur_q[k] > tgt_d[k]) begin
                        cur_d[k] = cur_q[k] - W'(1);
                    end
                end
            end

            act_d[k] = act_q[k];
            acc_d[k] = acc_q[k];
            pwm_d[k] = pwm_q[k];
            if (!en || mode_chg) begin
                act_d[k] = cur_q[k];
                acc_d[k] = '0;
                pwm_d[k] = 1'b0;
            end else if (mode) begin
                if (wrap) begin
                    act_d[k] = cur_q[k];
                end
                pwm_d[k] = (cnt_q < act_q[k]);
            end else begin
                act_d[k] = cur_q[k];
                acc_d[k] = {1'b0, acc_q[k][W-1:0]} + {1'b0, cur_q[k]};
                pwm_d[k] = acc_q[k][W];
            end
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tgt_q  <= '0;
            cur_q  <= '0;
            act_q  <= '0;
            acc_q  <= '0;
            pwm_q  <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
            pres_q <= '0;
            wrap_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            tgt_q  <= tgt_d;
            cur_q  <= cur_d;
            act_q  <= act_d;
            acc_q  <= acc_d;
            pwm_q  <= pwm_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            pres_q <= pres_d;
            wrap_q <= wrap_d;
            mode_q <= mode;
        end
    end

    assign PWM    = pwm_q;
    assign busy_o = busy_q;
    assign wrap_o = wrap_q;

endmodule
